// File: rtl/hex_display_scan_pkg.sv
// Shared constants for the hex display scanner: segment table, off pattern and
// the index-width helper used to size the scan counters.
package hex_display_pkg;

    // Active-high segment patterns for 0..F, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/hex_display_scan_if.sv
// System-side load bus and board-side display pins of the hex display scanner.
// master = system logic driving DATA/LOAD, slave = the scanner itself.
interface hex_display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] DATA;
    logic                    LOAD;
    logic [NUM_DIGITS-1:0]   BLANK;
    logic [NUM_DIGITS-1:0]   DP;
    logic [6:0]              HEX_SEG;
    logic                    HEX_DP;
    logic [NUM_DIGITS-1:0]   HEX_AN;
    logic                    FRAME;

    modport master (
        output DATA, LOAD, BLANK, DP,
        input  HEX_SEG, HEX_DP, HEX_AN, FRAME
    );

    modport slave (
        input  DATA, LOAD, BLANK, DP,
        output HEX_SEG, HEX_DP, HEX_AN, FRAME
    );
endinterface

// File: rtl/hex_display_scan_seg_decode.sv
// Combinational nibble to active-high 7-segment pattern.
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = seg_of(nibble_i);
endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex driver: prescaled digit scan, frame-aligned value update.
// Optional macro HEX_LZ_BLANK_EN enables leading-zero suppression.
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input logic               CLOCK_50,
    input logic               RESET,
    hex_display_scan_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);

    // Pin "off" levels double as the polarity mask for the active-high patterns.
    localparam logic [6:0]            SEG_PIN_OFF = {7{ACTIVE_LOW != 0}};
    localparam logic                  DP_PIN_OFF  = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF  = {NUM_DIGITS{ACTIVE_LOW != 0}};

    logic [PS_W-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                  tick, wrap, blank_sel;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg, seg_pat;
    logic [NUM_DIGITS-1:0] lz_blank;

    assign tick = (presc_q == PS_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        pend_vld_d   = pend_vld_q;
        frame_d      = wrap;

        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

        // A load landing on the wrap tick bypasses pending and goes live at once.
        if (wrap) begin
            if (bus.LOAD) begin
                act_data_d  = bus.DATA;
                act_blank_d = bus.BLANK;
                act_dp_d    = bus.DP;
            end else if (pend_vld_q) begin
                act_data_d  = pend_data_q;
                act_blank_d = pend_blank_q;
                act_dp_d    = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (bus.LOAD) begin
            pend_data_d  = bus.DATA;
            pend_blank_d = bus.BLANK;
            pend_dp_d    = bus.DP;
            pend_vld_d   = 1'b1;
        end
    end

`ifdef HEX_LZ_BLANK_EN
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (act_data_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign cur_nib   = act_data_q[4*int'(idx_q) +: 4];
    assign blank_sel = act_blank_q[idx_q] | lz_blank[idx_q];

    hex_seg_decode u_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_seg)
    );

    always_comb begin
        seg_pat = blank_sel ? SEG_OFF : cur_seg;
        seg_d   = seg_pat ^ SEG_PIN_OFF;
        dp_d    = (!blank_sel && act_dp_q[idx_q]) ^ DP_PIN_OFF;
        an_d    = (NUM_DIGITS'(1) << idx_q) ^ AN_PIN_OFF;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            presc_q      <= '0;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_blank_q  <= '0;
            act_dp_q     <= '0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= SEG_PIN_OFF;
            dp_q         <= DP_PIN_OFF;
            an_q         <= AN_PIN_OFF;
            frame_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.HEX_SEG = seg_q;
    assign bus.HEX_DP  = dp_q;
    assign bus.HEX_AN  = an_q;
    assign bus.FRAME   = frame_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan: active-low 4-digit slow scan (scoreboarded)
// and an active-high 6-digit scan stepping every cycle.
module tb_hex_display_scan;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   failures = 0;

`ifdef HEX_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    // Active-low pin patterns taken from the encoding table.
    localparam logic [6:0] L_0   = 7'b1000000;
    localparam logic [6:0] L_1   = 7'b1111001;
    localparam logic [6:0] L_2   = 7'b0100100;
    localparam logic [6:0] L_3   = 7'b0110000;
    localparam logic [6:0] L_8   = 7'b0000000;
    localparam logic [6:0] L_A   = 7'b0001000;
    localparam logic [6:0] L_F   = 7'b0001110;
    localparam logic [6:0] L_OFF = 7'b1111111;
    localparam logic [6:0] HI_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct {
        string      tag;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } exp_t;

    exp_t sb_q[$];

    hex_display_scan_if #(.NUM_DIGITS(4)) bus_a ();
    hex_display_scan_if #(.NUM_DIGITS(6)) bus_b ();

    hex_display_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut_a (
        .CLOCK_50 (clk),
        .RESET    (rst_a),
        .bus      (bus_a.slave)
    );

    hex_display_scan #(.NUM_DIGITS(6), .SCAN_DIV(1), .ACTIVE_LOW(0)) dut_b (
        .CLOCK_50 (clk),
        .RESET    (rst_b),
        .bus      (bus_b.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] zero_lo(input int d);
        return (d == 0 || !LZ) ? L_0 : L_OFF;
    endfunction

    function automatic logic [6:0] zero_hi(input int d);
        return (d == 0 || !LZ) ? HI_LUT[0] : 7'h00;
    endfunction

    task automatic push(input string tag, input logic [6:0] seg, input logic dp, input logic [3:0] an);
        exp_t e;
        e.tag = tag;
        e.seg = seg;
        e.dp  = dp;
        e.an  = an;
        sb_q.push_back(e);
    endtask

    task automatic push_digits(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        push({tag, "_d0"}, s0, 1'b1, AN_SEQ[0]);
        push({tag, "_d1"}, s1, 1'b1, AN_SEQ[1]);
        push({tag, "_d2"}, s2, 1'b1, AN_SEQ[2]);
        push({tag, "_d3"}, s3, 1'b1, AN_SEQ[3]);
    endtask

    // Pops each expectation when its digit next appears on HEX_AN.
    task automatic drain();
        exp_t e;
        bit   found;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            found = 1'b0;
            for (int n = 0; n < 40 && !found; n++) begin
                @(negedge clk);
                if (bus_a.HEX_AN === e.an) found = 1'b1;
            end
            check({e.tag, "_slot"}, 32'(found), 32'd1);
            check({e.tag, "_seg"}, 32'(bus_a.HEX_SEG), 32'(e.seg));
            check({e.tag, "_dp"}, 32'(bus_a.HEX_DP), 32'(e.dp));
        end
    endtask

    task automatic wait_frame_a();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (bus_a.FRAME === 1'b1) seen = 1'b1;
        end
        check("frame_a_seen", 32'(seen), 32'd1);
    endtask

    task automatic load_a(input logic [15:0] data, input logic [3:0] blank, input logic [3:0] dp);
        bus_a.DATA  = data;
        bus_a.BLANK = blank;
        bus_a.DP    = dp;
        bus_a.LOAD  = 1'b1;
        @(negedge clk);
        bus_a.LOAD  = 1'b0;
    endtask

    initial begin
        bit         seen;
        int         d;
        logic [5:0] an_b_exp;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.DATA = '0; bus_a.LOAD = 1'b0; bus_a.BLANK = '0; bus_a.DP = '0;
        bus_b.DATA = '0; bus_b.LOAD = 1'b0; bus_b.BLANK = '0; bus_b.DP = '0;
        repeat (3) @(negedge clk);

        // Reset state, both polarities
        check("rst_a_an", 32'(bus_a.HEX_AN), 32'h0F);
        check("rst_a_seg", 32'(bus_a.HEX_SEG), 32'(L_OFF));
        check("rst_a_dp", 32'(bus_a.HEX_DP), 32'd1);
        check("rst_a_frame", 32'(bus_a.FRAME), 32'd0);
        check("rst_b_an", 32'(bus_b.HEX_AN), 32'h00);
        check("rst_b_seg", 32'(bus_b.HEX_SEG), 32'h00);
        check("rst_b_dp", 32'(bus_b.HEX_DP), 32'd0);

        // Scan sequence: 4 cycles per digit, FRAME every 16 cycles
        rst_a = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            check($sformatf("scan_an_k%0d", k), 32'(bus_a.HEX_AN), 32'(AN_SEQ[d]));
            check($sformatf("scan_frame_k%0d", k), 32'(bus_a.FRAME), 32'(k % 16 == 0));
            check($sformatf("scan_seg_k%0d", k), 32'(bus_a.HEX_SEG), 32'(zero_lo(d)));
        end

        // Mid-frame load: current frame keeps old value, next frame shows 12AF
        repeat (6) @(negedge clk);
        push("midload_cur_d2", zero_lo(2), 1'b1, AN_SEQ[2]);
        load_a(16'h12AF, 4'b0000, 4'b0000);
        push_digits("midload", L_F, L_A, L_2, L_1);
        drain();

        // Load exactly on the wrap tick goes live on the very next digit0 slot
        wait_frame_a();
        repeat (15) @(negedge clk);
        load_a(16'h0003, 4'b0000, 4'b0000);
        push_digits("wrapload", L_3, zero_lo(1), zero_lo(2), zero_lo(3));
        drain();

        // Two loads in one frame: last one wins
        load_a(16'h1111, 4'b0000, 4'b0000);
        load_a(16'h2222, 4'b0000, 4'b0000);
        push_digits("lastwins", L_2, L_2, L_2, L_2);
        wait_frame_a();
        drain();

        // Blank mask and decimal points
        load_a(16'h8888, 4'b0100, 4'b0001);
        push("blank_d0", L_8, 1'b0, AN_SEQ[0]);
        push("blank_d1", L_8, 1'b1, AN_SEQ[1]);
        push("blank_d2", L_OFF, 1'b1, AN_SEQ[2]);
        push("blank_d3", L_8, 1'b1, AN_SEQ[3]);
        wait_frame_a();
        drain();

        // Leading zeros
        load_a(16'h0030, 4'b0000, 4'b0000);
        push_digits("lz", L_0, L_3, zero_lo(2), zero_lo(3));
        wait_frame_a();
        drain();

        // Reset during digit2 slot with a load pending
        wait_frame_a();
        repeat (5) @(negedge clk);
        load_a(16'h1234, 4'b0000, 4'b0000);
        repeat (4) @(negedge clk);
        check("prerst_an_d2", 32'(bus_a.HEX_AN), 32'(AN_SEQ[2]));
        #2 rst_a = 1'b1;
        #1;
        check("midrst_an", 32'(bus_a.HEX_AN), 32'h0F);
        check("midrst_seg", 32'(bus_a.HEX_SEG), 32'(L_OFF));
        check("midrst_dp", 32'(bus_a.HEX_DP), 32'd1);
        check("midrst_frame", 32'(bus_a.FRAME), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("postrst_an_d0", 32'(bus_a.HEX_AN), 32'(AN_SEQ[0]));
        check("postrst_seg_d0", 32'(bus_a.HEX_SEG), 32'(L_0));
        push("postrst_d1", zero_lo(1), 1'b1, AN_SEQ[1]);
        push("postrst_d2", zero_lo(2), 1'b1, AN_SEQ[2]);
        push("postrst_d3", zero_lo(3), 1'b1, AN_SEQ[3]);
        drain();
        // The dropped pending load must not appear at the following wrap
        wait_frame_a();
        push_digits("pendlost", L_0, zero_lo(1), zero_lo(2), zero_lo(3));
        drain();

        // Active-high, 6 digits, one digit per cycle
        rst_b = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            d = (k - 1) % 6;
            an_b_exp = 6'b000001 << d;
            check($sformatf("b_scan_an_k%0d", k), 32'(bus_b.HEX_AN), 32'(an_b_exp));
            check($sformatf("b_scan_frame_k%0d", k), 32'(bus_b.FRAME), 32'(k % 6 == 0));
            check($sformatf("b_scan_seg_k%0d", k), 32'(bus_b.HEX_SEG), 32'(zero_hi(d)));
        end
        bus_b.DATA = 24'h5A3C91;
        bus_b.DP   = 6'b100000;
        bus_b.LOAD = 1'b1;
        @(negedge clk);
        bus_b.LOAD = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus_b.FRAME === 1'b1) seen = 1'b1;
        end
        check("frame_b_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 6; i++) begin
            logic [23:0] val;
            val = 24'h5A3C91;
            @(negedge clk);
            an_b_exp = 6'b000001 << i;
            check($sformatf("b_load_an_d%0d", i), 32'(bus_b.HEX_AN), 32'(an_b_exp));
            check($sformatf("b_load_seg_d%0d", i), 32'(bus_b.HEX_SEG), 32'(HI_LUT[val[4*i +: 4]]));
            check($sformatf("b_load_dp_d%0d", i), 32'(bus_b.HEX_DP), 32'(i == 5));
        end
        #2 rst_b = 1'b1;
        #1;
        check("b_midrst_an", 32'(bus_b.HEX_AN), 32'h00);
        check("b_midrst_seg", 32'(bus_b.HEX_SEG), 32'h00);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_postrst_an", 32'(bus_b.HEX_AN), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
